hazard3_uart_dtm_rx: RTL

//  UART receiver for the UART DTM: 8N1 frames, 8x oversampled, majority vote per bit.

---
 rtl/hazard3_uart_dtm_rx_pkg.sv | 23 ++
 rtl/hazard3_uart_dtm_baudgen.sv | 30 +++
 rtl/hazard3_uart_dtm_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hazard3_uart_dtm_rx_pkg.sv
// Shared constants and types for the UART DTM serial blocks.
// Bit timing is 8 oversample phases per bit.
package hazard3_uart_dtm_rx_pkg;

  localparam logic [2:0] PHASE_S0   = 3'd3;
  localparam logic [2:0] PHASE_S1   = 3'd4;
  localparam logic [2:0] PHASE_VOTE = 3'd5;
  localparam logic [2:0] PHASE_LAST = 3'd7;
  localparam logic [2:0] LAST_BIT   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hazard3_uart_dtm_baudgen.sv
// Oversample tick generator: one tick every max(div,1) clocks.
// The restart input realigns the tick phase to a detected start edge.
module hazard3_uart_dtm_baudgen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term;

  assign term = (div == '0) ? '0 : div - DIV_W'(1);
  // >= rather than == so a shrinking div mid-count cannot stall ticks until wrap
  assign tick = !restart && (cnt >= term);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/hazard3_uart_dtm_rx.sv
// UART DTM receiver: 8N1, 8x oversampled with 3-sample majority vote per bit.
// Completed bytes go to a valid/ready hold register; bad or overrun bytes are dropped.
module hazard3_uart_dtm_rx
  import hazard3_uart_dtm_rx_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             rx,
  output logic [7:0]       wdata,
  output logic             wvld,
  input  logic             wrdy,
  output logic             err_frame,
  output logic             err_overrun
);

  logic      rx_s1;
  logic      rx_sync;
  rx_state_e state;
  logic [2:0] phase;
  logic [2:0] bit_cnt;
  logic [1:0] samp;
  logic [7:0] shift;
  logic       tick;
  logic       restart;
  logic       vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
    end
  end

  assign restart = en && (state == StIdle) && !rx_sync;
  assign vote    = maj3(samp[0], samp[1], rx_sync);

  hazard3_uart_dtm_baudgen #(
    .DIV_W (DIV_W)
  ) u_baudgen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .div     (div),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      phase       <= '0;
      bit_cnt     <= '0;
      samp        <= '0;
      shift       <= '0;
      wdata       <= '0;
      wvld        <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
      if (wvld && wrdy) wvld <= 1'b0;
      if (tick) begin
        if (phase == PHASE_S0) samp[0] <= rx_sync;
        if (phase == PHASE_S1) samp[1] <= rx_sync;
      end
      if (!en) begin
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (!rx_sync) begin
              state <= StStart;
              phase <= '0;
            end
          end
          StStart: begin
            if (tick) begin
              phase <= phase + 3'd1;
              if (phase == PHASE_VOTE && vote) begin
                state <= StIdle;
              end else if (phase == PHASE_LAST) begin
                state   <= StData;
                bit_cnt <= '0;
              end
            end
          end
          StData: begin
            if (tick) begin
              phase <= phase + 3'd1;
              if (phase == PHASE_VOTE) shift <= {vote, shift[7:1]};
              if (phase == PHASE_LAST) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == LAST_BIT) state <= StStop;
              end
            end
          end
          StStop: begin
            if (tick) begin
              phase <= phase + 3'd1;
              if (phase == PHASE_VOTE) begin
                if (vote) begin
                  // Return to idle mid stop bit so the next start edge is caught early
                  state <= StIdle;
                  if (!wvld || wrdy) begin
                    wdata <= shift;
                    wvld  <= 1'b1;
                  end else begin
                    err_overrun <= 1'b1;
                  end
                end else begin
                  state     <= StBreak;
                  err_frame <= 1'b1;
                end
              end
            end
          end
          StBreak: begin
            if (tick && rx_sync) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
